// File: rtl/multi_issue_dispatch.sv
// In-order multi-issue dispatch stage. Each cycle it issues the longest legal prefix of decoded lanes
// into a stallable output register toward EX, and keeps a per-register countdown for pending loads.
module multi_issue_dispatch #(
    parameter int ISSUE_WIDTH = 2,
    parameter int PAYLOAD_W   = 256,
    parameter int LOAD_LAT    = 1,
    parameter int MAX_MEM     = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic [ISSUE_WIDTH-1:0]             in_valid,
    input  logic [ISSUE_WIDTH-1:0]             in_is_priv,
    input  logic [ISSUE_WIDTH-1:0]             in_is_mem,
    input  logic [ISSUE_WIDTH-1:0]             in_is_load,
    input  logic [ISSUE_WIDTH-1:0]             in_rd_en,
    input  logic [ISSUE_WIDTH*5-1:0]           in_rd_addr,
    input  logic [ISSUE_WIDTH*2-1:0]           in_rs_en,
    input  logic [ISSUE_WIDTH*10-1:0]          in_rs_addr,
    input  logic [ISSUE_WIDTH*PAYLOAD_W-1:0]   in_payload,
    input  logic                               ex_ready,
    output logic [$clog2(ISSUE_WIDTH+1)-1:0]   accept_cnt,
    output logic                               stall_load,
    output logic [ISSUE_WIDTH-1:0]             out_valid,
    output logic [ISSUE_WIDTH*PAYLOAD_W-1:0]   out_payload
);
    localparam int W  = ISSUE_WIDTH;
    localparam int CW = $clog2(ISSUE_WIDTH+1);

    logic [31:1][2:0] sb, sb_nxt;
    logic [31:0]      busy;
    logic [W-1:0]     elig;
    logic [CW-1:0]    issue_cnt;
    logic             blk0, adv, kill;

    always_comb begin
        busy = '0;
        for (int r = 1; r < 32; r++) busy[r] = (sb[r] != 3'd0);
    end

    // Walk the lanes in order; the first stopping lane ends the group.
    always_comb begin
        int         mem_cnt;
        logic       stop, chain;
        logic [4:0] rs, rd;
        elig      = '0;
        issue_cnt = '0;
        blk0      = 1'b0;
        mem_cnt   = 0;
        chain     = 1'b1;
        stop      = 1'b0;
        rs        = '0;
        rd        = '0;
        for (int k = 0; k < W; k++) begin
            mem_cnt = mem_cnt + (in_is_mem[k] ? 1 : 0);
            stop    = (mem_cnt > MAX_MEM) || (k > 0 && (in_is_priv[k] || in_is_priv[0]));
            for (int s = 0; s < 2; s++) begin
                rs = in_rs_addr[(2*k+s)*5 +: 5];
                if (in_rs_en[2*k+s]) begin
                    if (busy[rs]) begin
                        stop = 1'b1;
                        if (k == 0) blk0 = 1'b1;
                    end
                    for (int j = 0; j < k; j++) begin
                        rd = in_rd_addr[j*5 +: 5];
                        if (in_rd_en[j] && rd != 5'd0 && rd == rs) stop = 1'b1;
                    end
                end
            end
            chain   = chain && in_valid[k] && !stop;
            elig[k] = chain;
            if (chain) issue_cnt = issue_cnt + CW'(1);
        end
    end

    assign kill       = rst | flush;
    assign adv        = ex_ready | ~|out_valid;
    assign accept_cnt = (adv && !kill) ? issue_cnt : '0;
    assign stall_load = !kill && in_valid[0] && blk0;

    // A newly issued load takes priority over the countdown of the same register.
    always_comb begin
        logic [31:0] set_m;
        set_m = '0;
        for (int k = 0; k < W; k++)
            if (adv && elig[k] && in_is_load[k] && in_rd_en[k]) set_m[in_rd_addr[k*5 +: 5]] = 1'b1;
        for (int r = 1; r < 32; r++) begin
            if (set_m[r])                 sb_nxt[r] = 3'(LOAD_LAT);
            else if (ex_ready && busy[r]) sb_nxt[r] = sb[r] - 3'd1;
            else                          sb_nxt[r] = sb[r];
        end
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            out_valid   <= '0;
            out_payload <= '0;
            sb          <= '0;
        end else begin
            sb <= sb_nxt;
            if (adv) begin
                out_valid <= elig;
                for (int k = 0; k < W; k++)
                    out_payload[k*PAYLOAD_W +: PAYLOAD_W] <= elig[k] ? in_payload[k*PAYLOAD_W +: PAYLOAD_W] : '0;
            end
        end
    end
endmodule

// File: tb/tb_multi_issue_dispatch.sv
// Bench for multi_issue_dispatch: a dual-issue instance (vector table + load/hold/flush sequences)
// and a 4-wide instance (directed group-limit checks + randomized run against a reference model).
module tb_multi_issue_dispatch;
    localparam int PW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // dual-issue instance, default LOAD_LAT/MAX_MEM
    logic            a_rst, a_flush, a_ex_ready, a_stall;
    logic [1:0]      a_valid, a_priv, a_mem, a_load, a_rd_en, a_acc, a_out_valid;
    logic [9:0]      a_rd_addr;
    logic [3:0]      a_rs_en;
    logic [19:0]     a_rs_addr;
    logic [2*PW-1:0] a_payload, a_out_payload;

    // 4-wide instance, LOAD_LAT=3, MAX_MEM=2
    logic            b_rst, b_flush, b_ex_ready, b_stall;
    logic [3:0]      b_valid, b_priv, b_mem, b_load, b_rd_en, b_out_valid;
    logic [2:0]      b_acc;
    logic [19:0]     b_rd_addr;
    logic [7:0]      b_rs_en;
    logic [39:0]     b_rs_addr;
    logic [4*PW-1:0] b_payload, b_out_payload;

    multi_issue_dispatch #(.ISSUE_WIDTH(2), .PAYLOAD_W(PW), .LOAD_LAT(1), .MAX_MEM(1)) u_dut2 (
        .clk(clk), .rst(a_rst), .flush(a_flush), .in_valid(a_valid), .in_is_priv(a_priv),
        .in_is_mem(a_mem), .in_is_load(a_load), .in_rd_en(a_rd_en), .in_rd_addr(a_rd_addr),
        .in_rs_en(a_rs_en), .in_rs_addr(a_rs_addr), .in_payload(a_payload), .ex_ready(a_ex_ready),
        .accept_cnt(a_acc), .stall_load(a_stall), .out_valid(a_out_valid), .out_payload(a_out_payload));

    multi_issue_dispatch #(.ISSUE_WIDTH(4), .PAYLOAD_W(PW), .LOAD_LAT(3), .MAX_MEM(2)) u_dut4 (
        .clk(clk), .rst(b_rst), .flush(b_flush), .in_valid(b_valid), .in_is_priv(b_priv),
        .in_is_mem(b_mem), .in_is_load(b_load), .in_rd_en(b_rd_en), .in_rd_addr(b_rd_addr),
        .in_rs_en(b_rs_en), .in_rs_addr(b_rs_addr), .in_payload(b_payload), .ex_ready(b_ex_ready),
        .accept_cnt(b_acc), .stall_load(b_stall), .out_valid(b_out_valid), .out_payload(b_out_payload));

    typedef struct {
        logic [1:0]  valid, priv, mem, rd_en;
        logic [9:0]  rd;
        logic [3:0]  rs_en;
        logic [19:0] rs;
        int          acc;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mkv(logic [1:0] v, logic [1:0] p, logic [1:0] m, logic [1:0] re,
                                 logic [9:0] rd, logic [3:0] se, logic [19:0] rs, int acc);
        vec_t t;
        t.valid = v; t.priv = p; t.mem = m; t.rd_en = re;
        t.rd = rd; t.rs_en = se; t.rs = rs; t.acc = acc;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_a();
        a_valid = '0; a_priv = '0; a_mem = '0; a_load = '0; a_rd_en = '0;
        a_rd_addr = '0; a_rs_en = '0; a_rs_addr = '0; a_payload = '0; a_flush = 1'b0;
    endtask

    task automatic idle_b();
        b_valid = '0; b_priv = '0; b_mem = '0; b_load = '0; b_rd_en = '0;
        b_rd_addr = '0; b_rs_en = '0; b_rs_addr = '0; b_payload = '0; b_flush = 1'b0;
    endtask

    task automatic set_a(input vec_t t);
        a_valid = t.valid; a_priv = t.priv; a_mem = t.mem; a_load = '0; a_rd_en = t.rd_en;
        a_rd_addr = t.rd; a_rs_en = t.rs_en; a_rs_addr = t.rs;
    endtask

    // load r7 in lane 0
    task automatic load7_a();
        idle_a();
        a_valid = 2'b01; a_mem = 2'b01; a_load = 2'b01; a_rd_en = 2'b01;
        a_rd_addr = {5'd0, 5'd7}; a_payload = {32'h0, 32'h1D_0007};
    endtask

    // add r8, r7, r0 in lane 0
    task automatic use7_a();
        idle_a();
        a_valid = 2'b01; a_rd_en = 2'b01; a_rd_addr = {5'd0, 5'd8};
        a_rs_en = 4'b0001; a_rs_addr = {15'd0, 5'd7}; a_payload = {32'h0, 32'hADD0_0087};
    endtask

    task automatic reset_a();
        @(negedge clk);
        idle_a(); a_rst = 1'b1; a_ex_ready = 1'b1;
        @(negedge clk);
        a_rst = 1'b0;
    endtask

    task automatic reset_b();
        @(negedge clk);
        idle_b(); b_rst = 1'b1; b_ex_ready = 1'b1;
        @(negedge clk);
        b_rst = 1'b0;
    endtask

    // reference model state for the 4-wide instance
    int          pend[32];
    logic [3:0]  m_ov;
    logic [127:0] m_op;

    task automatic model_step();
        int          n, mem_n, r;
        bit          ok, blk0, adv, exp_stall;
        logic [31:0] wset, setm;
        n = 0; mem_n = 0; blk0 = 0; wset = '0; setm = '0;
        for (int k = 0; k < 4; k++) begin
            ok = b_valid[k];
            mem_n += int'(b_mem[k]);
            if (mem_n > 2) ok = 0;
            if (k > 0 && (b_priv[k] || b_priv[0])) ok = 0;
            for (int s = 0; s < 2; s++) begin
                if (b_rs_en[2*k+s]) begin
                    r = int'(b_rs_addr[(2*k+s)*5 +: 5]);
                    if (pend[r] > 0) begin ok = 0; if (k == 0) blk0 = 1; end
                    if (wset[r]) ok = 0;
                end
            end
            if (!ok) break;
            n++;
            if (b_rd_en[k] && b_rd_addr[k*5 +: 5] != 5'd0) wset[b_rd_addr[k*5 +: 5]] = 1'b1;
        end
        adv       = b_ex_ready || (m_ov == 4'd0);
        exp_stall = b_valid[0] && blk0 && !b_flush;
        chk("rnd accept_cnt", 128'(b_acc), (adv && !b_flush) ? 128'(n) : 128'd0);
        chk("rnd stall_load", 128'(b_stall), 128'(exp_stall));
        chk("rnd out_valid", 128'(b_out_valid), 128'(m_ov));
        chk("rnd out_payload", b_out_payload, m_op);
        if (b_flush) begin
            foreach (pend[i]) pend[i] = 0;
            m_ov = '0; m_op = '0;
        end else begin
            if (adv)
                for (int k = 0; k < n; k++)
                    if (b_load[k] && b_rd_en[k] && b_rd_addr[k*5 +: 5] != 5'd0) setm[b_rd_addr[k*5 +: 5]] = 1'b1;
            for (int i = 1; i < 32; i++) begin
                if (setm[i]) pend[i] = 3;
                else if (b_ex_ready && pend[i] > 0) pend[i]--;
            end
            if (adv) begin
                m_ov = 4'((1 << n) - 1);
                m_op = '0;
                for (int k = 0; k < n; k++) m_op[k*PW +: PW] = b_payload[k*PW +: PW];
            end
        end
    endtask

    initial begin
        logic [1:0]  ev;
        logic [63:0] ep;
        int          nv;
        logic [3:0]  grp_mem[4], grp_priv[4];
        int          grp_acc[4];

        tbl[0]  = mkv(2'b11, 2'b00, 2'b00, 2'b11, {5'd4, 5'd1}, 4'b1111, {5'd6, 5'd5, 5'd3, 5'd2}, 2);
        tbl[1]  = mkv(2'b11, 2'b00, 2'b00, 2'b11, {5'd9, 5'd5}, 4'b1111, {5'd5, 5'd6, 5'd2, 5'd3}, 1);
        tbl[2]  = mkv(2'b11, 2'b00, 2'b00, 2'b11, {5'd9, 5'd0}, 4'b1111, {5'd0, 5'd6, 5'd2, 5'd3}, 2);
        tbl[3]  = mkv(2'b11, 2'b00, 2'b11, 2'b00, 10'd0, 4'b0000, 20'd0, 1);
        tbl[4]  = mkv(2'b11, 2'b10, 2'b00, 2'b00, 10'd0, 4'b0000, 20'd0, 1);
        tbl[5]  = mkv(2'b11, 2'b01, 2'b00, 2'b00, 10'd0, 4'b0000, 20'd0, 1);
        tbl[6]  = mkv(2'b00, 2'b00, 2'b00, 2'b00, 10'd0, 4'b0000, 20'd0, 0);
        tbl[7]  = mkv(2'b01, 2'b00, 2'b00, 2'b01, {5'd0, 5'd3}, 4'b0011, {10'd0, 5'd1, 5'd2}, 1);
        tbl[8]  = mkv(2'b11, 2'b00, 2'b00, 2'b00, {5'd9, 5'd5}, 4'b0100, {5'd0, 5'd5, 10'd0}, 2);
        tbl[9]  = mkv(2'b11, 2'b00, 2'b00, 2'b01, {5'd9, 5'd5}, 4'b0000, {5'd5, 5'd5, 10'd0}, 2);
        tbl[10] = mkv(2'b11, 2'b00, 2'b10, 2'b00, 10'd0, 4'b0000, 20'd0, 2);
        tbl[11] = mkv(2'b11, 2'b00, 2'b00, 2'b01, {5'd0, 5'd3}, 4'b1000, {5'd3, 15'd0}, 1);
        tbl[12] = mkv(2'b11, 2'b11, 2'b00, 2'b00, 10'd0, 4'b0000, 20'd0, 1);

        idle_a(); idle_b();
        a_ex_ready = 1'b1; b_ex_ready = 1'b1;

        // reset: combinational outputs forced low, register cleared
        a_rst = 1'b1; b_rst = 1'b1;
        set_a(tbl[0]); a_payload = 64'hCAFE_0001_BEEF_0002;
        #1;
        chk("rst accept_cnt", 128'(a_acc), 128'd0);
        chk("rst stall_load", 128'(a_stall), 128'd0);
        @(negedge clk);
        chk("rst out_valid", 128'(a_out_valid), 128'd0);
        chk("rst out_payload", 128'(a_out_payload), 128'd0);
        chk("rst b out_valid", 128'(b_out_valid), 128'd0);
        a_rst = 1'b0; b_rst = 1'b0;

        // vector table on the dual-issue instance
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            set_a(tbl[i]);
            a_payload  = {$urandom, $urandom};
            a_ex_ready = 1'b1;
            #1;
            chk($sformatf("tbl%0d accept_cnt", i), 128'(a_acc), 128'(tbl[i].acc));
            chk($sformatf("tbl%0d stall_load", i), 128'(a_stall), 128'd0);
            @(posedge clk);
            #1;
            ev = (tbl[i].acc == 0) ? 2'b00 : (tbl[i].acc == 1) ? 2'b01 : 2'b11;
            ep = {ev[1] ? a_payload[63:32] : 32'h0, ev[0] ? a_payload[31:0] : 32'h0};
            chk($sformatf("tbl%0d out_valid", i), 128'(a_out_valid), 128'(ev));
            chk($sformatf("tbl%0d out_payload", i), 128'(a_out_payload), 128'(ep));
        end

        // load-use: exactly one bubble
        reset_a();
        load7_a();
        #1 chk("lu load accept", 128'(a_acc), 128'd1);
        @(negedge clk);
        use7_a();
        #1;
        chk("lu stall accept", 128'(a_acc), 128'd0);
        chk("lu stall_load", 128'(a_stall), 128'd1);
        chk("lu load out", 128'(a_out_valid), 128'd1);
        @(negedge clk);
        #1;
        chk("lu bubble out", 128'(a_out_valid), 128'd0);
        chk("lu use accept", 128'(a_acc), 128'd1);
        chk("lu use stall", 128'(a_stall), 128'd0);

        // EX backpressure: output and scoreboard hold
        reset_a();
        load7_a();
        #1 chk("hold load accept", 128'(a_acc), 128'd1);
        @(negedge clk);
        use7_a();
        a_ex_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("hold%0d accept", c), 128'(a_acc), 128'd0);
            chk($sformatf("hold%0d stall", c), 128'(a_stall), 128'd1);
            chk($sformatf("hold%0d out_valid", c), 128'(a_out_valid), 128'd1);
            chk($sformatf("hold%0d out_payload", c), 128'(a_out_payload), 128'h1D_0007);
            @(negedge clk);
        end
        a_ex_ready = 1'b1;
        #1;
        chk("hold release stall", 128'(a_stall), 128'd1);
        chk("hold release accept", 128'(a_acc), 128'd0);
        @(negedge clk);
        #1;
        chk("hold bubble out", 128'(a_out_valid), 128'd0);
        chk("hold use accept", 128'(a_acc), 128'd1);
        @(negedge clk);
        #1;
        chk("hold use out", 128'(a_out_valid), 128'd1);
        chk("hold use payload", 128'(a_out_payload), 128'hADD0_0087);

        // flush while stalled clears everything; consumer goes next cycle
        reset_a();
        load7_a();
        @(negedge clk);
        use7_a();
        a_flush = 1'b1;
        #1;
        chk("flush stall forced", 128'(a_stall), 128'd0);
        chk("flush accept forced", 128'(a_acc), 128'd0);
        @(negedge clk);
        a_flush = 1'b0;
        #1;
        chk("flush out_valid", 128'(a_out_valid), 128'd0);
        chk("flush use accept", 128'(a_acc), 128'd1);
        chk("flush use stall", 128'(a_stall), 128'd0);

        // 4-wide group limits
        grp_mem  = '{4'b1101, 4'b0000, 4'b0000, 4'b0000};
        grp_priv = '{4'b0000, 4'b0010, 4'b0001, 4'b0000};
        grp_acc  = '{3, 1, 1, 4};
        reset_b();
        for (int g = 0; g < 4; g++) begin
            @(negedge clk);
            idle_b();
            b_valid = 4'hF; b_mem = grp_mem[g]; b_priv = grp_priv[g];
            #1 chk($sformatf("grp%0d accept_cnt", g), 128'(b_acc), 128'(grp_acc[g]));
        end

        // randomized run against the reference model
        reset_b();
        foreach (pend[i]) pend[i] = 0;
        m_ov = '0; m_op = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            nv = int'($urandom_range(0, 4));
            b_valid = 4'((1 << nv) - 1);
            for (int k = 0; k < 4; k++) begin
                b_priv[k]  = ($urandom_range(0, 9) == 0);
                b_mem[k]   = ($urandom_range(0, 2) == 0);
                b_load[k]  = b_mem[k] && ($urandom_range(0, 1) == 1);
                b_rd_en[k] = ($urandom_range(0, 3) != 0);
                b_rd_addr[k*5 +: 5] = 5'($urandom_range(0, 5));
                for (int s = 0; s < 2; s++) begin
                    b_rs_en[2*k+s] = ($urandom_range(0, 1) == 1);
                    b_rs_addr[(2*k+s)*5 +: 5] = 5'($urandom_range(0, 5));
                end
            end
            b_payload  = {$urandom, $urandom, $urandom, $urandom};
            b_ex_ready = ($urandom_range(0, 3) != 0);
            b_flush    = ($urandom_range(0, 24) == 0);
            #1 model_step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
